// File: rtl/mod_count_checker_pkg.sv
// Shared state encoding, seven-segment patterns and default modulus for the mod-count checker.
package mod_count_pkg;

    localparam int MOD_DEFAULT = 14;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LOCK  = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Active-high segments, bit order gfedcba, entry F down to entry 0.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/mod_count_checker_if.sv
// Count-sample bus between a modulo counter observer (master) and the checker (slave).
interface mod_count_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) ();
    logic             en;
    logic [WIDTH-1:0] count;
    logic             clr_err;
    logic             wrap;
    logic [CNT_W-1:0] wraps;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output en, count, clr_err,
        input  wrap, wraps, locked, err, err_cnt
    );

    modport slave (
        input  en, count, clr_err,
        output wrap, wraps, locked, err, err_cnt
    );
endinterface

// File: rtl/mod_count_checker_hex7seg.sv
// Combinational hex digit to seven-segment (gfedcba) decode; used only with MOD_COUNT_CHECKER_SEG_EN.
// Zero latency, no flow control.
module hex7seg
    import mod_count_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_LUT[i_val];
endmodule

// File: rtl/mod_count_checker.sv
// Checks a 0..MODULUS-1 counter sequence, counts wraps and fault entries; optional seg output via MOD_COUNT_CHECKER_SEG_EN.
// All outputs registered, 1-cycle latency; no backpressure, en qualifies each sample.
module mod_count_checker
    import mod_count_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = MOD_DEFAULT,
    parameter int CNT_W   = 8
) (
    input logic clk,
    input logic rst_n,
    mod_count_checker_if.slave bus
`ifdef MOD_COUNT_CHECKER_SEG_EN
    ,
    output logic [6:0] seg
`endif
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic             r_wrap;
    logic [CNT_W-1:0] r_wraps;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_prev_nxt;
    logic [WIDTH-1:0] w_exp;
    logic             w_wrap_nxt;
    logic [CNT_W-1:0] w_wraps_nxt;
    logic             w_fault;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_err_cnt_nxt;
    logic [CNT_W-1:0] w_err_cnt_inc;

    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_prev;
        w_wrap_nxt  = 1'b0;
        w_wraps_nxt = r_wraps;
        w_fault     = 1'b0;
        w_exp       = (r_prev == LAST) ? '0 : r_prev + 1'b1;

        if (bus.en) begin
            case (r_state)
                SYNC, FAULT: begin
                    if (bus.count == '0) begin
                        w_state_nxt = LOCK;
                        w_prev_nxt  = '0;
                    end
                end
                LOCK: begin
                    // Out-of-range counts can never equal w_exp, so they fault here too.
                    if (bus.count == w_exp) begin
                        w_prev_nxt = bus.count;
                        if (r_prev == LAST) begin
                            w_wrap_nxt  = 1'b1;
                            w_wraps_nxt = r_wraps + 1'b1;
                        end
                    end else begin
                        w_state_nxt = FAULT;
                        w_fault     = 1'b1;
                    end
                end
                default: w_state_nxt = SYNC;
            endcase
        end
    end

    assign w_err_cnt_inc = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;

    // A fault entry wins over clr_err; the clear only restarts the count from it.
    always_comb begin
        w_err_nxt     = r_err;
        w_err_cnt_nxt = r_err_cnt;
        if (w_fault) begin
            w_err_nxt     = 1'b1;
            w_err_cnt_nxt = bus.clr_err ? CNT_W'(1) : w_err_cnt_inc;
        end else if (bus.clr_err) begin
            w_err_nxt     = 1'b0;
            w_err_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= SYNC;
            r_prev    <= '0;
            r_wrap    <= 1'b0;
            r_wraps   <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_wrap    <= w_wrap_nxt;
            r_wraps   <= w_wraps_nxt;
            r_err     <= w_err_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign bus.wrap    = r_wrap;
    assign bus.wraps   = r_wraps;
    assign bus.locked  = (r_state == LOCK);
    assign bus.err     = r_err;
    assign bus.err_cnt = r_err_cnt;

`ifdef MOD_COUNT_CHECKER_SEG_EN
    logic [6:0] w_seg;
    logic [6:0] r_seg;

    hex7seg u_hex7seg (
        .i_val (bus.count[3:0]),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg <= 7'h00;
        end else if (bus.en) begin
            r_seg <= w_seg;
        end
    end

    assign seg = r_seg;
`endif

endmodule
